// File: rtl/mdio_master.sv
`default_nettype none
// ============================================================================
// Module   : mdio_master
// Brief    : Clause 22 MDIO management master. Accepts one read or write
//            command over valid/ready and generates the MDC/MDIO frame.
//            A read returns its data with a one-cycle rd_valid_o strobe.
// Revision : 1.0 - initial release
// ============================================================================
module mdio_master #(
    parameter int CLK_DIV       = 25,
    parameter int PREAMBLE_BITS = 32
) (
    input  logic        clk_i,
    input  logic        arst_n_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic [4:0]  cmd_phy_addr_i,
    input  logic [4:0]  cmd_reg_addr_i,
    input  logic [15:0] cmd_wdata_i,
    output logic        rd_valid_o,
    output logic [15:0] rd_data_o,
    output logic        busy_o,
    output logic        mdc_o,
    output logic        mdio_o,
    output logic        mdio_oe_o,
    input  logic        mdio_i
);

    // Parameter legality is checked while elaborating.
    generate
        if (CLK_DIV < 4 || CLK_DIV > 255) begin : g_bad_clk_div
            $error("mdio_master: CLK_DIV must be within 4..255");
        end
        if (PREAMBLE_BITS < 0 || PREAMBLE_BITS > 32) begin : g_bad_preamble
            $error("mdio_master: PREAMBLE_BITS must be within 0..32");
        end
    endgenerate

    localparam logic [7:0] C_DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [5:0] C_PRE_LAST = (PREAMBLE_BITS == 0) ? 6'd0 : 6'(PREAMBLE_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_HDR  = 3'd2,
        S_TA   = 3'd3,
        S_DATA = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_div, w_div_nxt;
    logic        r_phase, w_phase_nxt;       // 0 = MDC low phase, 1 = high phase
    logic [5:0]  r_bit, w_bit_nxt;           // bit index within the current state
    logic [31:0] r_shift, w_shift_nxt;       // MSB is the bit currently on the wire
    logic        r_write, w_write_nxt;
    logic        r_mdio, w_mdio_nxt;
    logic        r_oe, w_oe_nxt;
    logic        r_rd_valid, w_rd_valid_nxt;
    logic [15:0] r_rd_data, w_rd_data_nxt;
    logic        r_sync1, r_sync2;

    logic        w_accept;
    logic        w_in_frame;
    logic        w_bit_end;
    logic [31:0] w_frame;
    logic [31:0] w_shifted;

    assign w_accept   = cmd_valid_i && (r_state == S_IDLE);
    assign w_in_frame = (r_state == S_PRE) || (r_state == S_HDR) ||
                        (r_state == S_TA)  || (r_state == S_DATA);
    // Last cycle of the high phase: sample point and bit boundary.
    assign w_bit_end  = w_in_frame && r_phase && (r_div == C_DIV_LAST);
    assign w_frame    = {2'b01, (cmd_write_i ? 2'b01 : 2'b10), cmd_phy_addr_i,
                         cmd_reg_addr_i, 2'b10, (cmd_write_i ? cmd_wdata_i : 16'h0000)};
    // Every bit boundary after the preamble shifts out one bit and shifts in
    // one sample, so after DATA the low half holds the read value.
    assign w_shifted  = {r_shift[30:0], r_sync2};

    // Two-flop synchroniser for the asynchronous MDIO pad input.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= mdio_i;
            r_sync2 <= r_sync1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state    <= S_IDLE;
            r_div      <= 8'd0;
            r_phase    <= 1'b0;
            r_bit      <= 6'd0;
            r_shift    <= 32'd0;
            r_write    <= 1'b0;
            r_mdio     <= 1'b1;
            r_oe       <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= 16'h0000;
        end else begin
            r_state    <= w_state_nxt;
            r_div      <= w_div_nxt;
            r_phase    <= w_phase_nxt;
            r_bit      <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_write    <= w_write_nxt;
            r_mdio     <= w_mdio_nxt;
            r_oe       <= w_oe_nxt;
            r_rd_valid <= w_rd_valid_nxt;
            r_rd_data  <= w_rd_data_nxt;
        end
    end

    // Next-state logic; MDIO outputs are updated only at bit boundaries so
    // they change exactly when MDC falls.
    always_comb begin
        w_state_nxt    = r_state;
        w_div_nxt      = r_div;
        w_phase_nxt    = r_phase;
        w_bit_nxt      = r_bit;
        w_shift_nxt    = r_shift;
        w_write_nxt    = r_write;
        w_mdio_nxt     = r_mdio;
        w_oe_nxt       = r_oe;
        w_rd_valid_nxt = 1'b0;
        w_rd_data_nxt  = r_rd_data;

        if (w_in_frame) begin
            if (r_div == C_DIV_LAST) begin
                w_div_nxt   = 8'd0;
                w_phase_nxt = ~r_phase;
            end else begin
                w_div_nxt = r_div + 8'd1;
            end
        end

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_write_nxt = cmd_write_i;
                    w_shift_nxt = w_frame;
                    w_div_nxt   = 8'd0;
                    w_phase_nxt = 1'b0;
                    w_bit_nxt   = 6'd0;
                    w_oe_nxt    = 1'b1;
                    if (PREAMBLE_BITS == 0) begin
                        w_state_nxt = S_HDR;
                        w_mdio_nxt  = w_frame[31];
                    end else begin
                        w_state_nxt = S_PRE;
                        w_mdio_nxt  = 1'b1;
                    end
                end
            end
            S_PRE: begin
                if (w_bit_end) begin
                    w_oe_nxt = 1'b1;
                    if (r_bit == C_PRE_LAST) begin
                        w_state_nxt = S_HDR;
                        w_bit_nxt   = 6'd0;
                        w_mdio_nxt  = r_shift[31];
                    end else begin
                        w_bit_nxt  = r_bit + 6'd1;
                        w_mdio_nxt = 1'b1;
                    end
                end
            end
            S_HDR: begin
                if (w_bit_end) begin
                    w_shift_nxt = w_shifted;
                    w_mdio_nxt  = r_shift[30];
                    if (r_bit == 6'd13) begin
                        w_state_nxt = S_TA;
                        w_bit_nxt   = 6'd0;
                        w_oe_nxt    = r_write;
                    end else begin
                        w_bit_nxt = r_bit + 6'd1;
                    end
                end
            end
            S_TA: begin
                if (w_bit_end) begin
                    w_shift_nxt = w_shifted;
                    w_mdio_nxt  = r_write ? r_shift[30] : 1'b1;
                    w_oe_nxt    = r_write;
                    if (r_bit == 6'd1) begin
                        w_state_nxt = S_DATA;
                        w_bit_nxt   = 6'd0;
                    end else begin
                        w_bit_nxt = r_bit + 6'd1;
                    end
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_shift_nxt = w_shifted;
                    if (r_bit == 6'd15) begin
                        w_state_nxt = S_DONE;
                        w_bit_nxt   = 6'd0;
                        w_mdio_nxt  = 1'b1;
                        w_oe_nxt    = 1'b0;
                        if (!r_write) begin
                            w_rd_data_nxt  = w_shifted[15:0];
                            w_rd_valid_nxt = 1'b1;
                        end
                    end else begin
                        w_bit_nxt  = r_bit + 6'd1;
                        w_mdio_nxt = r_write ? r_shift[30] : 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_div_nxt   = 8'd0;
                w_phase_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign cmd_ready_o = (r_state == S_IDLE);
    assign busy_o      = ~cmd_ready_o;
    assign mdc_o       = r_phase;
    assign mdio_o      = r_mdio;
    assign mdio_oe_o   = r_oe;
    assign rd_valid_o  = r_rd_valid;
    assign rd_data_o   = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_mdio_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdio_master
// Brief    : Directed self-checking bench for mdio_master. Three instances:
//            0 = CLK_DIV 4 / 32 preamble, 1 = CLK_DIV 4 / no preamble,
//            2 = CLK_DIV 25 / 32 preamble.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdio_master;

    localparam logic [63:0] C_EXP_W1 = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd1, 5'd0, 2'b10, 16'h1140};
    localparam logic [63:0] C_EXP_A  = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd2, 5'd4, 2'b10, 16'h0F0F};
    localparam logic [63:0] C_EXP_B  = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd7, 5'd9, 2'b10, 16'hA5C3};
    localparam logic [63:0] C_EXP_R  = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd6, 5'd17, 2'b10, 16'h8001};
    localparam logic [63:0] C_EXP_C  = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd31, 5'd31, 2'b10, 16'h5555};

    logic            clk;
    logic [2:0]      arst_n;
    logic [2:0]      cmd_valid;
    logic [2:0]      cmd_write;
    logic [2:0][4:0] cmd_phy;
    logic [2:0][4:0] cmd_reg;
    logic [2:0][15:0] cmd_wdata;
    logic [2:0]      mdio_in;
    logic [2:0]      cmd_ready;
    logic [2:0]      rd_valid;
    logic [2:0][15:0] rd_data;
    logic [2:0]      busy;
    logic [2:0]      mdc;
    logic [2:0]      mdio_out;
    logic [2:0]      mdio_oe;

    int total = 0;
    int bad   = 0;

    // Observations filled in by capture().
    logic [63:0] cap_bits;
    int cap_nbits, cap_busy, cap_oe1, cap_first_oe0, cap_rdv, cap_rdv_n;
    int cap_hi_min, cap_hi_max, cap_lo_min, cap_lo_max;
    logic cap_last_mdc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mdio_master #(.CLK_DIV(4), .PREAMBLE_BITS(32)) u_dut0 (
        .clk_i(clk), .arst_n_i(arst_n[0]), .cmd_valid_i(cmd_valid[0]), .cmd_ready_o(cmd_ready[0]),
        .cmd_write_i(cmd_write[0]), .cmd_phy_addr_i(cmd_phy[0]), .cmd_reg_addr_i(cmd_reg[0]),
        .cmd_wdata_i(cmd_wdata[0]), .rd_valid_o(rd_valid[0]), .rd_data_o(rd_data[0]),
        .busy_o(busy[0]), .mdc_o(mdc[0]), .mdio_o(mdio_out[0]), .mdio_oe_o(mdio_oe[0]),
        .mdio_i(mdio_in[0]));

    mdio_master #(.CLK_DIV(4), .PREAMBLE_BITS(0)) u_dut1 (
        .clk_i(clk), .arst_n_i(arst_n[1]), .cmd_valid_i(cmd_valid[1]), .cmd_ready_o(cmd_ready[1]),
        .cmd_write_i(cmd_write[1]), .cmd_phy_addr_i(cmd_phy[1]), .cmd_reg_addr_i(cmd_reg[1]),
        .cmd_wdata_i(cmd_wdata[1]), .rd_valid_o(rd_valid[1]), .rd_data_o(rd_data[1]),
        .busy_o(busy[1]), .mdc_o(mdc[1]), .mdio_o(mdio_out[1]), .mdio_oe_o(mdio_oe[1]),
        .mdio_i(mdio_in[1]));

    mdio_master #(.CLK_DIV(25), .PREAMBLE_BITS(32)) u_dut2 (
        .clk_i(clk), .arst_n_i(arst_n[2]), .cmd_valid_i(cmd_valid[2]), .cmd_ready_o(cmd_ready[2]),
        .cmd_write_i(cmd_write[2]), .cmd_phy_addr_i(cmd_phy[2]), .cmd_reg_addr_i(cmd_reg[2]),
        .cmd_wdata_i(cmd_wdata[2]), .rd_valid_o(rd_valid[2]), .rd_data_o(rd_data[2]),
        .busy_o(busy[2]), .mdc_o(mdc[2]), .mdio_o(mdio_out[2]), .mdio_oe_o(mdio_oe[2]),
        .mdio_i(mdio_in[2]));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a command and return in the first frame cycle (cycle after accept).
    task automatic issue(input int d, input logic w, input logic [4:0] phy,
                         input logic [4:0] rega, input logic [15:0] data);
        int k;
        cmd_write[d] = w;
        cmd_phy[d]   = phy;
        cmd_reg[d]   = rega;
        cmd_wdata[d] = data;
        cmd_valid[d] = 1'b1;
        k = 0;
        while (!cmd_ready[d] && k < 100) begin
            step();
            k++;
        end
        total++;
        if (k >= 100) begin
            bad++;
            $display("FAIL issue_ready dut=%0d got ready=%0b want 1", d, cmd_ready[d]);
        end
        step();
    endtask

    // Observe one frame cycle by cycle, starting at frame cycle 0, and act as
    // the PHY during DATA of a read. Stops at the first idle cycle, or right
    // after asserting reset at frame cycle abort_n.
    task automatic capture(input int d, input int cd, input int pre, input bit phy_drive,
                           input logic [15:0] phy_data, input bit hold, input int chg_n,
                           input int abort_n);
        int n, run, b;
        logic cur, prev;
        logic [3:0] idx;
        n = 0; run = 0; cur = 1'b0; prev = 1'b0;
        cap_bits = 64'd0; cap_nbits = 0; cap_busy = 0; cap_oe1 = 0; cap_first_oe0 = -1;
        cap_rdv = 0; cap_rdv_n = -1; cap_last_mdc = 1'b0;
        cap_hi_min = 1000000; cap_hi_max = 0; cap_lo_min = 1000000; cap_lo_max = 0;
        while (n < 10000) begin
            if (n == abort_n) begin
                arst_n[d] = 1'b0;
                break;
            end
            if (!busy[d]) break;
            if (n == 0 && !hold) cmd_valid[d] = 1'b0;
            if (n == chg_n) begin
                cmd_write[d] = 1'b1;
                cmd_phy[d]   = 5'd7;
                cmd_reg[d]   = 5'd9;
                cmd_wdata[d] = 16'hA5C3;
            end
            b = n / (2 * cd);
            if (phy_drive && b >= pre + 16 && b < pre + 32) begin
                idx = 4'(15 - (b - pre - 16));
                mdio_in[d] = phy_data[idx];
            end else begin
                mdio_in[d] = 1'b1;
            end
            cap_busy++;
            if (mdio_oe[d]) cap_oe1++;
            else if (cap_first_oe0 < 0) cap_first_oe0 = n;
            if (rd_valid[d]) begin
                cap_rdv++;
                cap_rdv_n = n;
            end
            if (n > 0 && mdc[d] && !prev) begin
                cap_bits = {cap_bits[62:0], mdio_out[d]};
                cap_nbits++;
            end
            if (n == 0) begin
                cur = mdc[d];
                run = 1;
            end else if (mdc[d] == cur) begin
                run++;
            end else begin
                if (cur) begin
                    if (run < cap_hi_min) cap_hi_min = run;
                    if (run > cap_hi_max) cap_hi_max = run;
                end else begin
                    if (run < cap_lo_min) cap_lo_min = run;
                    if (run > cap_lo_max) cap_lo_max = run;
                end
                cur = mdc[d];
                run = 1;
            end
            prev = mdc[d];
            cap_last_mdc = mdc[d];
            step();
            n++;
        end
        mdio_in[d] = 1'b1;
    endtask

    task automatic test_reset();
        arst_n = 3'b000;
        cmd_valid = '0; cmd_write = '0; cmd_phy = '0; cmd_reg = '0; cmd_wdata = '0;
        mdio_in = 3'b111;
        repeat (3) step();
        for (int d = 0; d < 3; d++) begin
            total++;
            if (mdc[d] !== 1'b0 || mdio_out[d] !== 1'b1 || mdio_oe[d] !== 1'b0) begin
                bad++;
                $display("FAIL reset_pins dut=%0d got mdc/mdio/oe=%b%b%b want 010", d, mdc[d], mdio_out[d], mdio_oe[d]);
            end
            total++;
            if (cmd_ready[d] !== 1'b1 || busy[d] !== 1'b0) begin
                bad++;
                $display("FAIL reset_ready dut=%0d got ready/busy=%b%b want 10", d, cmd_ready[d], busy[d]);
            end
            total++;
            if (rd_valid[d] !== 1'b0 || rd_data[d] !== 16'h0000) begin
                bad++;
                $display("FAIL reset_rd dut=%0d got valid=%b data=%h want 0 0000", d, rd_valid[d], rd_data[d]);
            end
        end
        arst_n = 3'b111;
        repeat (3) step();
        total++;
        if (cmd_ready !== 3'b111 || mdc !== 3'b000) begin
            bad++;
            $display("FAIL reset_release got ready=%b mdc=%b want 111 000", cmd_ready, mdc);
        end
    endtask

    task automatic test_write();
        issue(0, 1'b1, 5'd1, 5'd0, 16'h1140);
        capture(0, 4, 32, 1'b0, 16'h0000, 1'b0, -1, -1);
        total++;
        if (cap_bits !== C_EXP_W1 || cap_nbits !== 64) begin
            bad++;
            $display("FAIL write_bits got=%h n=%0d want=%h n=64", cap_bits, cap_nbits, C_EXP_W1);
        end
        total++;
        if (cap_busy !== 513) begin
            bad++;
            $display("FAIL write_len got=%0d want=513", cap_busy);
        end
        total++;
        if (cap_oe1 !== 512 || cap_first_oe0 !== 512) begin
            bad++;
            $display("FAIL write_oe got ones=%0d first0=%0d want 512 512", cap_oe1, cap_first_oe0);
        end
        total++;
        if (cap_rdv !== 0) begin
            bad++;
            $display("FAIL write_rdvalid got=%0d want=0", cap_rdv);
        end
        total++;
        if (cap_hi_min !== 4 || cap_hi_max !== 4 || cap_lo_min !== 4 || cap_lo_max !== 4) begin
            bad++;
            $display("FAIL write_mdc got hi=%0d..%0d lo=%0d..%0d want 4", cap_hi_min, cap_hi_max, cap_lo_min, cap_lo_max);
        end
        total++;
        if (cmd_ready[0] !== 1'b1 || mdc[0] !== 1'b0) begin
            bad++;
            $display("FAIL write_idle got ready=%b mdc=%b want 1 0", cmd_ready[0], mdc[0]);
        end
    endtask

    task automatic test_read();
        issue(0, 1'b0, 5'd3, 5'd2, 16'hDEAD);
        capture(0, 4, 32, 1'b1, 16'h0141, 1'b0, -1, -1);
        total++;
        if (cap_bits[31:18] !== 14'b01_10_00011_00010) begin
            bad++;
            $display("FAIL read_hdr got=%b want=01100001100010", cap_bits[31:18]);
        end
        total++;
        if (cap_first_oe0 !== 368 || cap_oe1 !== 368) begin
            bad++;
            $display("FAIL read_oe got first0=%0d ones=%0d want 368 368", cap_first_oe0, cap_oe1);
        end
        total++;
        if (cap_rdv !== 1 || cap_rdv_n !== 512) begin
            bad++;
            $display("FAIL read_rdvalid got count=%0d at=%0d want 1 at 512", cap_rdv, cap_rdv_n);
        end
        total++;
        if (rd_data[0] !== 16'h0141 || cap_busy !== 513) begin
            bad++;
            $display("FAIL read_data got=%h len=%0d want=0141 len=513", rd_data[0], cap_busy);
        end
        repeat (10) step();
        total++;
        if (rd_data[0] !== 16'h0141 || rd_valid[0] !== 1'b0) begin
            bad++;
            $display("FAIL read_hold got data=%h valid=%b want 0141 0", rd_data[0], rd_valid[0]);
        end
    endtask

    task automatic test_no_preamble();
        issue(1, 1'b0, 5'd4, 5'd1, 16'h0000);
        capture(1, 4, 0, 1'b0, 16'h0000, 1'b0, -1, -1);
        total++;
        if (cap_busy !== 257 || cap_nbits !== 32) begin
            bad++;
            $display("FAIL nopre_len got=%0d bits=%0d want 257 32", cap_busy, cap_nbits);
        end
        total++;
        if (cap_bits[31:18] !== 14'b01_10_00100_00001) begin
            bad++;
            $display("FAIL nopre_hdr got=%b want=01100010000001", cap_bits[31:18]);
        end
        total++;
        if (cap_rdv !== 1 || rd_data[1] !== 16'hFFFF) begin
            bad++;
            $display("FAIL nopre_data got count=%0d data=%h want 1 FFFF", cap_rdv, rd_data[1]);
        end
    endtask

    task automatic test_back_to_back();
        issue(0, 1'b1, 5'd2, 5'd4, 16'h0F0F);
        capture(0, 4, 32, 1'b0, 16'h0000, 1'b1, 100, -1);
        total++;
        if (cap_bits !== C_EXP_A) begin
            bad++;
            $display("FAIL b2b_first got=%h want=%h", cap_bits, C_EXP_A);
        end
        total++;
        if (cap_last_mdc !== 1'b0 || cmd_ready[0] !== 1'b1 || mdc[0] !== 1'b0) begin
            bad++;
            $display("FAIL b2b_gap got done_mdc=%b ready=%b mdc=%b want 0 1 0", cap_last_mdc, cmd_ready[0], mdc[0]);
        end
        step();
        total++;
        if (busy[0] !== 1'b1 || mdc[0] !== 1'b0) begin
            bad++;
            $display("FAIL b2b_accept got busy=%b mdc=%b want 1 0", busy[0], mdc[0]);
        end
        capture(0, 4, 32, 1'b0, 16'h0000, 1'b0, -1, -1);
        total++;
        if (cap_bits !== C_EXP_B || cap_busy !== 513) begin
            bad++;
            $display("FAIL b2b_second got=%h len=%0d want=%h len=513", cap_bits, cap_busy, C_EXP_B);
        end
    endtask

    task automatic test_async_reset();
        issue(0, 1'b0, 5'd3, 5'd2, 16'h0000);
        capture(0, 4, 32, 1'b1, 16'hBEEF, 1'b0, -1, (32 + 16 + 5) * 8 + 3);
        #1;
        total++;
        if (mdc[0] !== 1'b0 || mdio_out[0] !== 1'b1 || mdio_oe[0] !== 1'b0) begin
            bad++;
            $display("FAIL arst_pins got mdc/mdio/oe=%b%b%b want 010", mdc[0], mdio_out[0], mdio_oe[0]);
        end
        total++;
        if (cmd_ready[0] !== 1'b1 || busy[0] !== 1'b0 || rd_valid[0] !== 1'b0 || rd_data[0] !== 16'h0000) begin
            bad++;
            $display("FAIL arst_state got ready=%b busy=%b valid=%b data=%h want 1 0 0 0000",
                     cmd_ready[0], busy[0], rd_valid[0], rd_data[0]);
        end
        total++;
        if (cap_rdv !== 0) begin
            bad++;
            $display("FAIL arst_rdvalid got=%0d want=0", cap_rdv);
        end
        step();
        arst_n[0] = 1'b1;
        step();
        issue(0, 1'b1, 5'd6, 5'd17, 16'h8001);
        capture(0, 4, 32, 1'b0, 16'h0000, 1'b0, -1, -1);
        total++;
        if (cap_bits !== C_EXP_R || cap_busy !== 513 || cap_rdv !== 0) begin
            bad++;
            $display("FAIL arst_after got=%h len=%0d rdv=%0d want=%h 513 0", cap_bits, cap_busy, cap_rdv, C_EXP_R);
        end
    endtask

    task automatic test_clk_div25();
        int hi;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (mdc[2]) hi++;
            step();
        end
        issue(2, 1'b1, 5'd31, 5'd31, 16'h5555);
        capture(2, 25, 32, 1'b0, 16'h0000, 1'b0, -1, -1);
        total++;
        if (cap_hi_min !== 25 || cap_hi_max !== 25 || cap_lo_min !== 25 || cap_lo_max !== 25) begin
            bad++;
            $display("FAIL div25_mdc got hi=%0d..%0d lo=%0d..%0d want 25", cap_hi_min, cap_hi_max, cap_lo_min, cap_lo_max);
        end
        total++;
        if (cap_busy !== 3201 || cap_bits !== C_EXP_C) begin
            bad++;
            $display("FAIL div25_frame got len=%0d bits=%h want 3201 %h", cap_busy, cap_bits, C_EXP_C);
        end
        for (int i = 0; i < 20; i++) begin
            if (mdc[2]) hi++;
            step();
        end
        total++;
        if (hi !== 0) begin
            bad++;
            $display("FAIL div25_idle got mdc high cycles=%0d want 0", hi);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_no_preamble();
        test_back_to_back();
        test_async_reset();
        test_clk_div25();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
